fetch_unit_pq: RTL and testbench
================================

Name: fetch_unit_pq

Overview:
Parametrised instruction fetch stage with a prefetch queue. It holds the PC and issues in-order word fetches over a valid/ready instruction-memory request port. Responses are buffered with their PCs in a small FIFO, which feeds decode through a valid/ready handshake. A taken redirect from execute (PC_src/PC_target) flushes the queue and squashes any in-flight responses.

Parameters:
XLEN, 32, PC and instruction width
DEPTH, 4, prefetch queue entries (power of 2, >=2); also the cap on queued plus outstanding fetches
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_OUTSTANDING, 2, maximum issued requests not yet responded to (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
PC_src  in  1  redirect strobe, single cycle
PC_target  in  XLEN  redirect address, sampled when PC_src=1
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response valid; responses are in order, latency >=1 cycle
imem_rsp_data  in  XLEN  fetched instruction
instruction_F  out  XLEN  head-of-queue instruction
PC_F  out  XLEN  PC of head-of-queue instruction
valid_F  out  1  head entry valid
ready_D  in  1  decode accepts the head entry (stall when 0)

Behaviour:
- Reset (async assert): fetch PC=RESET_PC; queue empty; outstanding=0; drop counter=0. Outputs: valid_F=0, imem_req_valid=0, instruction_F=0, PC_F=0.
- Issue: imem_req_valid=1 when !rst, !PC_src, outstanding<MAX_OUTSTANDING, and count+outstanding<DEPTH. imem_req_addr is the fetch PC, bits[1:0] forced to 0. On valid&&ready, fetch PC += 4 (wraps modulo 2^XLEN) and outstanding increments.
- Response: when imem_rsp_valid=1 and the drop counter is 0, push {PC, data} into the queue tail. The PC comes from a side FIFO of issued addresses, depth MAX_OUTSTANDING. When the drop counter is >0, discard the response and decrement the counter. Outstanding decrements on every response.
- Space guarantee: the issue rule ensures a push never finds the queue full. An overflow is an assertion failure.
- Dequeue: head pops when valid_F && ready_D. instruction_F/PC_F are registered from the head entry and stay stable while valid_F && !ready_D.
- Simultaneous push and pop: both happen; count unchanged. With an empty queue, a pushed entry appears at valid_F the next cycle. Minimum fetch-to-decode latency is memory latency + 1 cycle.
- Redirect (PC_src=1):
  - Next cycle: fetch PC=PC_target (bits[1:0] cleared), queue emptied, valid_F=0.
  - Drop counter loads the outstanding count after this cycle's accept/response updates, so stale responses are discarded.
  - No request issues in the redirect cycle. A pop by decode in that cycle is still honoured.
  - A response arriving in the redirect cycle is discarded.
- Back-to-back redirects: the last one wins. The drop counter accumulates correctly because it is recomputed from outstanding each time.
- Reset mid-operation: all state returns to reset values immediately. Responses arriving after reset deassertion for pre-reset requests are not the block's responsibility; memory is reset together with the block.
- Counters: width clog2(DEPTH)+1 and clog2(MAX_OUTSTANDING)+1; no overflow by construction.

Decomposition:
- Shared package fetch_pkg holds XLEN, RESET_PC default, the fetch_entry_t struct {pc, instr}, and the PC increment constant 4.
- One natural sub-module: fetch_fifo. It is a parametrised synchronous FIFO (WIDTH, DEPTH) with push/pop/flush, full/empty/count, and async active-high reset.
- It is instantiated twice: as the prefetch queue and as the issued-address side FIFO.

Test Plan:
1. Reset with RESET_PC=0x100, imem ready=1, latency 1, ready_D=1 -> requests 0x100, 0x104, 0x108 on consecutive cycles. valid_F first rises 2 cycles after the first accept, with PC_F=0x100 and instruction_F=mem[0x100]; then one instruction per cycle.
2. Hold ready_D=0 for 10 cycles -> queue fills to DEPTH=4, then imem_req_valid drops. The head stays stable (PC_F=0x100). Releasing ready_D drains 0x100..0x10C in order, then issue resumes at 0x110.
3. Latency 3 with 2 outstanding, assert PC_src with PC_target=0x200 -> both stale responses are dropped. The next valid_F shows PC_F=0x200; no 0x1xx instruction is presented after the redirect.
4. PC_src in the same cycle as a response and a decode pop -> the response is discarded, the pop is completed, and the queue is empty next cycle. The first request after the redirect issues 0x200 one cycle after PC_src.
5. imem_req_ready toggling randomly with PC_target=0xFFFF_FFFC -> address sequence 0xFFFF_FFFC, 0x0000_0000 (wrap). No address is skipped or duplicated.
6. Assert rst asynchronously mid-burst with the queue at 3 entries -> valid_F and imem_req_valid go to 0 without a clock edge. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its queues.
package fetch_pkg;
    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int              PC_INC           = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; used for the prefetch queue and the issued-address side queue.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps the pointers correct for non power-of-2 depths.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) assert (!(push && full));
    end
endmodule

// File: rtl/fetch_unit_pq.sv
// Fetch stage: in-order word fetches into a prefetch queue, with redirect flush
// and squashing of responses that belong to the abandoned path.
module fetch_unit_pq
    import fetch_pkg::*;
#(
    parameter int              XLEN            = fetch_pkg::XLEN,
    parameter int              DEPTH           = 4,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(fetch_pkg::RESET_PC_DEFAULT),
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PC_src,
    input  logic [XLEN-1:0] PC_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] instruction_F,
    output logic [XLEN-1:0] PC_F,
    output logic            valid_F,
    input  logic            ready_D
);
    localparam int              QCW        = $clog2(DEPTH) + 1;
    localparam int              OCW        = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0]   pc;
    logic [OCW-1:0]    drop_cnt;
    logic [OCW-1:0]    out_cnt;
    logic [QCW-1:0]    q_count;
    logic              q_full;
    logic              q_empty;
    logic              side_full;
    logic              side_empty;
    logic [2*XLEN-1:0] q_head;
    logic [XLEN-1:0]   side_head;
    logic              req_fire;
    logic              rsp_fire;
    logic              q_push;
    logic              q_pop;

    assign imem_req_addr = pc & ALIGN_MASK;

    // Queued plus in-flight fetches never exceed DEPTH, so every response has a slot.
    always_comb begin
        imem_req_valid = !rst && !PC_src && !side_full && !q_full
                         && (int'(out_cnt) < MAX_OUTSTANDING)
                         && (int'(q_count) + int'(out_cnt) < DEPTH);
    end

    assign req_fire      = imem_req_valid && imem_req_ready;
    assign rsp_fire      = imem_rsp_valid && !side_empty;
    assign q_push        = rsp_fire && (drop_cnt == '0) && !PC_src;
    assign valid_F       = !q_empty;
    assign q_pop         = valid_F && ready_D;
    assign PC_F          = q_head[2*XLEN-1:XLEN];
    assign instruction_F = q_head[XLEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC & ALIGN_MASK;
            drop_cnt <= '0;
        end else if (PC_src) begin
            pc       <= PC_target & ALIGN_MASK;
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt <= out_cnt - OCW'(rsp_fire);
        end else begin
            if (req_fire) pc <= pc + XLEN'(PC_INC);
            if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - OCW'(1);
        end
    end

    // Outstanding count is the side queue occupancy; it pops on every response.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_side_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (req_fire),
        .wr_data (imem_req_addr),
        .pop     (rsp_fire),
        .flush   (1'b0),
        .rd_data (side_head),
        .full    (side_full),
        .empty   (side_empty),
        .count   (out_cnt)
    );

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_prefetch_q (
        .clk     (clk),
        .rst     (rst),
        .push    (q_push),
        .wr_data ({side_head, imem_rsp_data}),
        .pop     (q_pop),
        .flush   (PC_src),
        .rd_data (q_head),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );
endmodule

// File: tb/tb_fetch_unit_pq.sv
// Self-checking bench for fetch_unit_pq: in-order memory model plus a queue-level
// reference of what decode must see and when fetches may issue.
module tb_fetch_unit_pq;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PC_src = 1'b0;
    logic [31:0] PC_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] instruction_F;
    logic [31:0] PC_F;
    logic        valid_F;
    logic        ready_D = 1'b0;

    fetch_unit_pq #(
        .XLEN            (32),
        .DEPTH           (DEPTH),
        .RESET_PC        (RST_PC),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PC_src         (PC_src),
        .PC_target      (PC_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instruction_F  (instruction_F),
        .PC_F           (PC_F),
        .valid_F        (valid_F),
        .ready_D        (ready_D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } pend_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc;
    int          epoch;
    int          last_due;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rand_ready;
    bit          prev_stall;
    bit          last_rsp;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic [31:0] exp_issue;
    pend_t       pend[$];
    logic [31:0] mq[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] pop_log[$];
    int          first_valid_cyc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        PC_src = 1'b0;
        imem_rsp_valid = 1'b0;
        pend.delete();
        mq.delete();
        acc_addr.delete();
        acc_cyc.delete();
        pop_log.delete();
        exp_issue = RST_PC;
        epoch = 0;
        last_due = -1;
        cyc = 0;
        prev_stall = 0;
        first_valid_cyc = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        pend_t       h;
        bit          rsp;
        bit          acc;
        bit          pop;
        bit          exp_req;
        int          due;
        logic [31:0] hp;
        imem_req_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        rsp = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memf(pend[0].addr) : $urandom;
        last_rsp = rsp;
        #1;
        n_checks++;
        if (valid_F !== (mq.size() > 0)) begin
            n_fail++;
            $display("FAIL valid_F cyc=%0d got=%b exp=%b", cyc, valid_F, mq.size() > 0);
        end
        exp_req = !PC_src && (pend.size() < MAX_OUT) && (mq.size() + pend.size() < DEPTH);
        n_checks++;
        if (imem_req_valid !== exp_req) begin
            n_fail++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req);
        end
        if (prev_stall) begin
            n_checks++;
            if (PC_F !== prev_pc || instruction_F !== prev_instr) begin
                n_fail++;
                $display("FAIL head_stable cyc=%0d got=%h/%h exp=%h/%h", cyc, PC_F, instruction_F, prev_pc, prev_instr);
            end
        end
        acc = imem_req_valid && imem_req_ready;
        pop = valid_F && ready_D;
        if (valid_F && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pop && mq.size() > 0) begin
            hp = mq.pop_front();
            n_checks++;
            if (PC_F !== hp || instruction_F !== memf(hp)) begin
                n_fail++;
                $display("FAIL pop cyc=%0d got=%h/%h exp=%h/%h", cyc, PC_F, instruction_F, hp, memf(hp));
            end
            pop_log.push_back(PC_F);
        end
        if (rsp) begin
            h = pend.pop_front();
            if (!PC_src && h.epoch == epoch) mq.push_back(h.addr);
        end
        if (acc) begin
            n_checks++;
            if (imem_req_addr !== exp_issue) begin
                n_fail++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_issue);
            end
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            h.addr = imem_req_addr;
            h.due = due;
            h.epoch = epoch;
            pend.push_back(h);
            acc_addr.push_back(imem_req_addr);
            acc_cyc.push_back(cyc);
            exp_issue = exp_issue + 32'd4;
        end
        if (PC_src) begin
            mq.delete();
            epoch++;
            exp_issue = PC_target & ~32'd3;
        end
        prev_stall = valid_F && !ready_D && !PC_src;
        prev_pc = PC_F;
        prev_instr = instruction_F;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        PC_src = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (valid_F !== 1'b0 || imem_req_valid !== 1'b0 || PC_F !== 32'h0 || instruction_F !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b/%b/%h/%h exp=0/0/0/0", valid_F, imem_req_valid, PC_F, instruction_F);
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat_min = 1; lat_max = 1; rand_ready = 0; ready_D = 1'b1;
        repeat (10) step();
        n_checks++;
        if (acc_addr.size() < 3 || acc_addr[0] !== 32'h100 || acc_addr[1] !== 32'h104 || acc_addr[2] !== 32'h108
            || acc_cyc[1] != acc_cyc[0] + 1 || acc_cyc[2] != acc_cyc[1] + 1) begin
            n_fail++;
            $display("FAIL stream_first_reqs got_count=%0d exp=3 consecutive from 100", acc_addr.size());
        end
        n_checks++;
        if (acc_cyc.size() == 0 || first_valid_cyc != acc_cyc[0] + 2) begin
            n_fail++;
            $display("FAIL stream_latency got=%0d exp=2", first_valid_cyc - (acc_cyc.size() > 0 ? acc_cyc[0] : 0));
        end
        n_checks++;
        if (pop_log.size() != cyc - first_valid_cyc) begin
            n_fail++;
            $display("FAIL stream_rate got=%0d exp=%0d", pop_log.size(), cyc - first_valid_cyc);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat_min = 1; lat_max = 1; rand_ready = 0; ready_D = 1'b0;
        repeat (10) step();
        #1;
        n_checks++;
        if (acc_addr.size() != DEPTH || valid_F !== 1'b1 || PC_F !== 32'h100 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_fill got=%0d/%b/%h/%b exp=4/1/100/0", acc_addr.size(), valid_F, PC_F, imem_req_valid);
        end
        @(negedge clk);
        cyc++;
        prev_stall = 0;
        ready_D = 1'b1;
        repeat (8) step();
        n_checks++;
        if (pop_log.size() < 4 || pop_log[0] !== 32'h100 || pop_log[1] !== 32'h104
            || pop_log[2] !== 32'h108 || pop_log[3] !== 32'h10C) begin
            n_fail++;
            $display("FAIL drain_order got_count=%0d exp=4 from 100", pop_log.size());
        end
        n_checks++;
        if (acc_addr.size() < 5 || acc_addr[4] !== 32'h110) begin
            n_fail++;
            $display("FAIL resume_addr got=%h exp=110", acc_addr.size() > 4 ? acc_addr[4] : 32'hx);
        end
    endtask

    task automatic test_redirect_inflight();
        int base;
        int npop;
        bit bad;
        do_reset();
        lat_min = 3; lat_max = 3; rand_ready = 0; ready_D = 1'b1;
        for (int i = 0; i < 20 && pend.size() < 2; i++) step();
        n_checks++;
        if (pend.size() != 2) begin
            n_fail++;
            $display("FAIL redir_setup got=%0d exp=2 outstanding", pend.size());
        end
        PC_src = 1'b1; PC_target = 32'h200;
        step();
        base = pop_log.size();
        npop = base;
        for (int i = 0; i < 30 && pop_log.size() == npop; i++) step();
        n_checks++;
        if (pop_log.size() == base || pop_log[base] !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_first_pc got=%h exp=200", pop_log.size() > base ? pop_log[base] : 32'hx);
        end
        repeat (10) step();
        bad = 0;
        for (int i = base; i < pop_log.size(); i++)
            if (pop_log[i] < 32'h200) bad = 1;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL redir_stale got=stale pc presented exp=none");
        end
    endtask

    task automatic test_redirect_same_cycle();
        int npop;
        do_reset();
        lat_min = 1; lat_max = 1; rand_ready = 0; ready_D = 1'b1;
        repeat (8) step();
        npop = pop_log.size();
        PC_src = 1'b1; PC_target = 32'h200;
        step();
        n_checks++;
        if (pop_log.size() != npop + 1 || !last_rsp) begin
            n_fail++;
            $display("FAIL redir_pop got=%0d pops rsp=%b exp=1 pop rsp=1", pop_log.size() - npop, last_rsp);
        end
        #1;
        n_checks++;
        if (valid_F !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_next got=%b/%b/%h exp=0/1/200", valid_F, imem_req_valid, imem_req_addr);
        end
        repeat (6) step();
    endtask

    task automatic test_wrap_random();
        bit found;
        do_reset();
        lat_min = 1; lat_max = 3; rand_ready = 1; ready_D = 1'b1;
        repeat (5) step();
        PC_src = 1'b1; PC_target = 32'hFFFF_FFFE;
        step();
        for (int i = 0; i < 80; i++) begin
            ready_D = ($urandom_range(0, 3) != 0);
            step();
        end
        found = 0;
        for (int i = 0; i + 1 < acc_addr.size(); i++)
            if (acc_addr[i] === 32'hFFFF_FFFC && acc_addr[i+1] === 32'h0) found = 1;
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wrap got=no FFFFFFFC->0 pair exp=pair present");
        end
        rand_ready = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        lat_min = 1; lat_max = 1; rand_ready = 0; ready_D = 1'b0;
        for (int i = 0; i < 20 && mq.size() < 3; i++) step();
        n_checks++;
        if (mq.size() != 3) begin
            n_fail++;
            $display("FAIL arst_setup got=%0d exp=3 entries", mq.size());
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (valid_F !== 1'b0 || imem_req_valid !== 1'b0 || PC_F !== 32'h0) begin
            n_fail++;
            $display("FAIL arst_outputs got=%b/%b/%h exp=0/0/0", valid_F, imem_req_valid, PC_F);
        end
        do_reset();
        ready_D = 1'b1;
        repeat (6) step();
        n_checks++;
        if (acc_addr.size() == 0 || acc_addr[0] !== RST_PC) begin
            n_fail++;
            $display("FAIL arst_restart got=%h exp=%h", acc_addr.size() > 0 ? acc_addr[0] : 32'hx, RST_PC);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_wrap_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=no finish exp=finish");
        $fatal(1, "timeout");
    end
endmodule
